fft_iter_addr_gen: RTL and testbench

- Address generator for the iterative radix-2 in-place FFT. Sits directly downstream of the iterative FFT control unit and consumes its LAY_EN / ADDR_EN / Wr / FIRST strobes.
- Produces per-butterfly read addresses (operand pair), the twiddle ROM index, and write-back addresses. Write-back addresses are buffered in a small FIFO so that butterfly pipeline latency is decoupled from the read issue.
- N = 2^LAYERS points, BUTTERFLYES = N/2 butterflies per layer.

---
 rtl/fft_iter_addr_gen.sv | 186 ++++++++++++++++++
 tb/tb_fft_iter_addr_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iter_addr_gen.sv
// Address generator for the iterative radix-2 in-place FFT.
// Issues read/twiddle addresses and buffers write-back addresses in a FIFO.
module fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_AW     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              LAY_EN,
    input  logic              ADDR_EN,
    input  logic              WR,
    input  logic              FIRST,
    output logic [LAYERS-1:0] RD_ADDR_A,
    output logic [LAYERS-1:0] RD_ADDR_B,
    output logic [LAYERS-2:0] TW_ADDR,
    output logic              RD_VLD,
    output logic [LAYERS-1:0] WR_ADDR_A,
    output logic [LAYERS-1:0] WR_ADDR_B,
    output logic              WR_VLD,
    output logic              DONE,
    output logic              ERR
);

    localparam int TW_W = LAYERS - 1;
    localparam int EW   = 2 * LAYERS + 1;
    localparam int CW   = FIFO_AW + 1;

    logic [ButtWL-1:0]  b_q, b_d, b_use;
    logic [LayWL-1:0]   s_q, s_d, s_use;
    logic [LAYERS-1:0]  rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [TW_W-1:0]    tw_q, tw_d;
    logic               rd_vld_q, rd_vld_d;
    logic [LAYERS-1:0]  wr_a_q, wr_a_d, wr_b_q, wr_b_d;
    logic               wr_vld_q, wr_vld_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [EW-1:0]      mem_q [FIFO_DEPTH];

    logic [LAYERS-1:0]  b_ext, mask, a, bb, a_rev, bb_rev;
    logic [TW_W-1:0]    tw;
    logic               last, full, empty, push_ok, pop_ok;
    logic [EW-1:0]      head;

    assign head  = mem_q[rp_q];
    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);

    // Resolve effective b/s for this butterfly and derive its addresses
    always_comb begin
        b_use = b_q;
        s_use = s_q;
        if (LAY_EN) begin
            b_use = '0;
            if (FIRST) begin
                s_use = '0;
            end else if (s_q != LayWL'(LAYERS - 1)) begin
                s_use = s_q + 1'b1;
            end
        end
        b_ext = LAYERS'(b_use);
        mask  = (LAYERS'(1) << s_use) - LAYERS'(1);
        a     = ((b_ext >> s_use) << (int'(s_use) + 1)) | (b_ext & mask);
        bb    = a | (LAYERS'(1) << s_use);
        tw    = TW_W'((b_ext & mask) << (LAYERS - 1 - int'(s_use)));
        last  = (s_use == LayWL'(LAYERS - 1)) &&
                (b_use == ButtWL'(BUTTERFLYES - 1));
        for (int i = 0; i < LAYERS; i++) begin
            a_rev[i]  = a[LAYERS-1-i];
            bb_rev[i] = bb[LAYERS-1-i];
        end
    end

    // Next-state for counters, read/write outputs, FIFO bookkeeping and ERR
    always_comb begin
        pop_ok   = WR && !empty;
        push_ok  = ADDR_EN && (!full || pop_ok);
        b_d      = b_q;
        s_d      = s_q;
        rd_a_d   = rd_a_q;
        rd_b_d   = rd_b_q;
        tw_d     = tw_q;
        rd_vld_d = ADDR_EN;
        wr_a_d   = wr_a_q;
        wr_b_d   = wr_b_q;
        wr_vld_d = pop_ok;
        done_d   = pop_ok && head[0];
        err_d    = err_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        if (ADDR_EN) begin
            b_d    = b_use + 1'b1;
            s_d    = s_use;
            rd_a_d = FIRST ? a_rev : a;
            rd_b_d = FIRST ? bb_rev : bb;
            tw_d   = tw;
            if (LAY_EN && b_q != '0) begin
                err_d = 1'b1;
            end
            if (LAY_EN && !FIRST && s_q == LayWL'(LAYERS - 1)) begin
                err_d = 1'b1;
            end
            if (!push_ok) begin
                err_d = 1'b1;
            end
        end
        if (WR && empty) begin
            err_d = 1'b1;
        end
        if (pop_ok) begin
            wr_a_d = head[EW-1 -: LAYERS];
            wr_b_d = head[LAYERS:1];
        end
        if (push_ok) begin
            wp_d = wp_q + 1'b1;
        end
        if (pop_ok) begin
            rp_d = rp_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State registers: reset wins, EN=0 freezes everything
    always_ff @(posedge CLK) begin
        if (!RST) begin
            b_q      <= '0;
            s_q      <= '0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
            tw_q     <= '0;
            rd_vld_q <= 1'b0;
            wr_a_q   <= '0;
            wr_b_q   <= '0;
            wr_vld_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
        end else if (EN) begin
            b_q      <= b_d;
            s_q      <= s_d;
            rd_a_q   <= rd_a_d;
            rd_b_q   <= rd_b_d;
            tw_q     <= tw_d;
            rd_vld_q <= rd_vld_d;
            wr_a_q   <= wr_a_d;
            wr_b_q   <= wr_b_d;
            wr_vld_q <= wr_vld_d;
            done_q   <= done_d;
            err_q    <= err_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset
    always_ff @(posedge CLK) begin
        if (RST && EN && push_ok) begin
            mem_q[wp_q] <= {a, bb, last};
        end
    end

    assign RD_ADDR_A = rd_a_q;
    assign RD_ADDR_B = rd_b_q;
    assign TW_ADDR   = tw_q;
    assign RD_VLD    = rd_vld_q;
    assign WR_ADDR_A = wr_a_q;
    assign WR_ADDR_B = wr_b_q;
    assign WR_VLD    = wr_vld_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Directed self-checking bench for fft_iter_addr_gen.
// Covers reset, layer addressing, full transform, FIFO limits and EN hold.
module tb_fft_iter_addr_gen;

    logic       CLK = 1'b0;
    logic       RST, EN, LAY_EN, ADDR_EN, WR, FIRST;
    logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
    logic [3:0] TW_ADDR;
    logic       RD_VLD, WR_VLD, DONE, ERR;

    int n_err = 0;
    int n_chk = 0;
    int rd_cnt, wr_cnt, dn_cnt;

    always #5 CLK = ~CLK;

    fft_iter_addr_gen dut (
        .CLK(CLK), .RST(RST), .EN(EN), .LAY_EN(LAY_EN),
        .ADDR_EN(ADDR_EN), .WR(WR), .FIRST(FIRST),
        .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
        .TW_ADDR(TW_ADDR), .RD_VLD(RD_VLD),
        .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B),
        .WR_VLD(WR_VLD), .DONE(DONE), .ERR(ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic en, input logic lay, input logic ad,
                       input logic wr, input logic first);
        EN = en; LAY_EN = lay; ADDR_EN = ad; WR = wr; FIRST = first;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rda"}, RD_ADDR_A, 0);
        chk({tag, "_rdb"}, RD_ADDR_B, 0);
        chk({tag, "_tw"}, TW_ADDR, 0);
        chk({tag, "_rdv"}, RD_VLD, 0);
        chk({tag, "_wra"}, WR_ADDR_A, 0);
        chk({tag, "_wrb"}, WR_ADDR_B, 0);
        chk({tag, "_wrv"}, WR_VLD, 0);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_err"}, ERR, 0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        drv(1, 0, 0, 0, 0);
        cyc();
        RST = 1'b1;
    endtask

    function automatic int m_a(input int b, input int s);
        return (b / (1 << s)) * (1 << (s + 1)) + (b % (1 << s));
    endfunction

    function automatic int m_tw(input int b, input int s);
        return (b % (1 << s)) * (1 << (4 - s));
    endfunction

    function automatic int rev5(input int x);
        int r = 0;
        for (int i = 0; i < 5; i++) if (x & (1 << i)) r |= 1 << (4 - i);
        return r;
    endfunction

    initial begin
        int ea, eb, ex;
        RST = 1'b0;
        drv(0, 0, 0, 0, 0);

        // reset with random strobes
        for (int i = 0; i < 3; i++) begin
            drv(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            cyc();
            chk_zero("rst");
        end
        RST = 1'b1;
        drv(1, 0, 0, 0, 0);
        cyc();
        cyc();
        chk_zero("post_rst");

        // layer 0 up to b=3
        drv(1, 1, 1, 0, 1);
        cyc();
        chk("l0_b0_rda", RD_ADDR_A, 0);
        chk("l0_b0_rdb", RD_ADDR_B, 16);
        drv(1, 0, 1, 0, 1);
        cyc();
        cyc();
        cyc();
        chk("l0_b3_rdv", RD_VLD, 1);
        chk("l0_b3_rda", RD_ADDR_A, 12);
        chk("l0_b3_rdb", RD_ADDR_B, 28);
        chk("l0_b3_tw", TW_ADDR, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 1, 1);
            cyc();
            chk("l0_wrv", WR_VLD, 1);
            chk("l0_rdv", RD_VLD, 0);
            chk("l0_wra", WR_ADDR_A, 2 * i);
            chk("l0_wrb", WR_ADDR_B, 2 * i + 1);
        end
        chk("l0_err", ERR, 0);

        // full transform with R/W alternation
        do_reset();
        rd_cnt = 0; wr_cnt = 0; dn_cnt = 0;
        for (int s = 0; s < 5; s++) begin
            for (int b = 0; b < 16; b++) begin
                drv(1, b == 0, 1, 0, s == 0);
                cyc();
                rd_cnt += RD_VLD; wr_cnt += WR_VLD; dn_cnt += DONE;
                ea = m_a(b, s);
                eb = ea | (1 << s);
                chk("tf_rdv", RD_VLD, 1);
                chk("tf_rda", RD_ADDR_A, (s == 0) ? rev5(ea) : ea);
                chk("tf_rdb", RD_ADDR_B, (s == 0) ? rev5(eb) : eb);
                chk("tf_tw", TW_ADDR, m_tw(b, s));
                if (s == 2 && b == 5) begin
                    chk("l2_b5_rda", RD_ADDR_A, 9);
                    chk("l2_b5_rdb", RD_ADDR_B, 13);
                    chk("l2_b5_tw", TW_ADDR, 4);
                end
                if (s == 4 && b == 15) chk("last_tw", TW_ADDR, 15);
                drv(1, 0, 0, 1, s == 0);
                cyc();
                rd_cnt += RD_VLD; wr_cnt += WR_VLD; dn_cnt += DONE;
                chk("tf_wrv", WR_VLD, 1);
                chk("tf_wra", WR_ADDR_A, ea);
                chk("tf_wrb", WR_ADDR_B, eb);
                chk("tf_done", DONE, (s == 4 && b == 15) ? 1 : 0);
            end
        end
        chk("last_wra", WR_ADDR_A, 15);
        chk("last_wrb", WR_ADDR_B, 31);
        chk("last_done", DONE, 1);
        drv(1, 0, 0, 0, 0);
        cyc();
        rd_cnt += RD_VLD; wr_cnt += WR_VLD; dn_cnt += DONE;
        chk("done_pulse", DONE, 0);
        chk("rd_pulses", rd_cnt, 80);
        chk("wr_pulses", wr_cnt, 80);
        chk("done_pulses", dn_cnt, 1);
        chk("tf_err", ERR, 0);

        // FIFO overflow then drain
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, i == 0, 1, 0, 1);
            cyc();
        end
        chk("ov_err0", ERR, 0);
        drv(1, 0, 1, 0, 1);
        cyc();
        chk("ov_err1", ERR, 1);
        chk("ov_rdv", RD_VLD, 1);
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 0, 1, 1);
            cyc();
            chk("ov_wrv", WR_VLD, (i < 4) ? 1 : 0);
            ex = (i < 4) ? 2 * i : 6;
            chk("ov_wra", WR_ADDR_A, ex);
            chk("ov_wrb", WR_ADDR_B, ex + 1);
        end
        chk("ov_err_sticky", ERR, 1);

        // underflow on empty FIFO
        do_reset();
        drv(1, 0, 0, 1, 0);
        cyc();
        chk("un_wrv", WR_VLD, 0);
        chk("un_err", ERR, 1);

        // push+pop on empty: underflow, push kept
        do_reset();
        drv(1, 1, 1, 1, 1);
        cyc();
        chk("pp_wrv", WR_VLD, 0);
        chk("pp_err", ERR, 1);
        drv(1, 0, 0, 1, 1);
        cyc();
        chk("pp_wrv2", WR_VLD, 1);
        chk("pp_wra", WR_ADDR_A, 0);
        chk("pp_wrb", WR_ADDR_B, 1);

        // LAY_EN with b != 0 is a protocol error
        do_reset();
        drv(1, 1, 1, 0, 1);
        cyc();
        drv(1, 1, 1, 0, 1);
        cyc();
        chk("lay_err", ERR, 1);
        chk("lay_rda", RD_ADDR_A, 0);

        // EN=0 freeze mid-layer
        do_reset();
        drv(1, 1, 1, 0, 1);
        cyc();
        drv(1, 0, 1, 0, 1);
        cyc();
        drv(1, 0, 0, 1, 1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drv(0, i[0], ~i[0], i[1], i[0]);
            cyc();
            chk("en_rdv", RD_VLD, 0);
            chk("en_wrv", WR_VLD, 1);
            chk("en_rda", RD_ADDR_A, 8);
            chk("en_rdb", RD_ADDR_B, 24);
            chk("en_wra", WR_ADDR_A, 0);
            chk("en_err", ERR, 0);
        end
        drv(1, 0, 1, 0, 1);
        cyc();
        chk("res_rda", RD_ADDR_A, 4);
        chk("res_rdb", RD_ADDR_B, 20);
        drv(1, 0, 0, 1, 1);
        cyc();
        chk("res_wra1", WR_ADDR_A, 2);
        cyc();
        chk("res_wra2", WR_ADDR_A, 4);
        chk("res_wrb2", WR_ADDR_B, 5);
        chk("res_err", ERR, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
